// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//   Consumes one-cycle byte strobes from a UART receiver, hunts for a sync
//   byte, collects a length-prefixed payload into an internal buffer, verifies
//   an 8-bit additive checksum and only then releases the payload on a
//   valid/ready byte stream. Bad or stalled frames are dropped and flagged.
//
// Ports
//   i_Clock       system clock, all logic on posedge
//   i_Reset       synchronous active-high reset
//   i_RX_DV       byte strobe from the receiver (1 cycle)
//   i_RX_Byte     received byte, qualified by i_RX_DV
//   o_Data        payload byte on offer (0 when nothing is offered)
//   o_Data_Valid  o_Data valid, held until accepted
//   o_Data_Last   final payload byte of the frame
//   i_Data_Ready  consumer accepts o_Data on valid & ready
//   o_Frame_Err   1-cycle pulse: frame discarded
//   o_Err_Code    with o_Frame_Err: 01 bad LEN, 10 checksum, 11 timeout
//   o_Overrun     1-cycle pulse: byte dropped because it arrived during delivery
//   o_Busy        high whenever not hunting for a sync byte
module uart_rx_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 3480
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW    = $clog2(TIMEOUT_CLKS);

  typedef enum logic [2:0] {
    S_HUNT,
    S_GET_LEN,
    S_GET_PAY,
    S_GET_CHK,
    S_DELIVER
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             ovr_q, ovr_d;
  logic             mem_we;
  logic [7:0]       mem_q [MAX_LEN];

  logic [IDX_W-1:0] last_idx;
  logic [7:0]       chk_sum;
  logic             collecting;
  logic             tmo_hit;

  assign last_idx   = len_q - IDX_W'(1);
  assign chk_sum    = acc_q + i_RX_Byte;
  assign collecting = (state_q == S_GET_LEN) || (state_q == S_GET_PAY) ||
                      (state_q == S_GET_CHK);
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CLKS - 1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    tmo_d   = '0;
    err_d   = 1'b0;
    code_d  = 2'b00;
    ovr_d   = 1'b0;
    mem_we  = 1'b0;

    // Inter-byte timeout: a strobe always wins over an expiring count.
    if (collecting && !i_RX_DV) begin
      if (tmo_hit) begin
        err_d   = 1'b1;
        code_d  = 2'b11;
        state_d = S_HUNT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    case (state_q)
      S_HUNT: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = S_GET_LEN;
      end
      S_GET_LEN: begin
        if (i_RX_DV) begin
          if ((i_RX_Byte == 8'd0) || (i_RX_Byte > 8'(MAX_LEN))) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_HUNT;
          end else begin
            len_d   = i_RX_Byte[IDX_W-1:0];
            acc_d   = i_RX_Byte;
            idx_d   = '0;
            state_d = S_GET_PAY;
          end
        end
      end
      S_GET_PAY: begin
        if (i_RX_DV) begin
          mem_we = 1'b1;
          acc_d  = chk_sum;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == last_idx) state_d = S_GET_CHK;
        end
      end
      S_GET_CHK: begin
        if (i_RX_DV) begin
          if (chk_sum == 8'd0) begin
            idx_d   = '0;
            state_d = S_DELIVER;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_HUNT;
          end
        end
      end
      S_DELIVER: begin
        // Buffer is read-only while draining; late bytes are dropped.
        ovr_d = i_RX_DV;
        if (i_Data_Ready) begin
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = S_HUNT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_HUNT;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  // Payload buffer carries data only; it is never read outside DELIVER.
  always_ff @(posedge i_Clock) begin
    if (mem_we) mem_q[idx_q[AW-1:0]] <= i_RX_Byte;
  end

  assign o_Data_Valid = (state_q == S_DELIVER);
  assign o_Data       = o_Data_Valid ? mem_q[idx_q[AW-1:0]] : 8'h00;
  assign o_Data_Last  = o_Data_Valid && (idx_q == last_idx);
  assign o_Frame_Err  = err_q;
  assign o_Err_Code   = code_q;
  assign o_Overrun    = ovr_q;
  assign o_Busy       = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Testbench for uart_rx_frame_parser: table of directed frames plus
// hand-written sequences for reset, backpressure/overrun, timeout,
// mid-frame reset and a maximum-length frame.
module tb_uart_rx_frame_parser;

  localparam int TMO = 3480;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, last, ferr, ovr, busy;
  logic [1:0] code;

  always #5 clk = ~clk;

  uart_rx_frame_parser dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_RX_DV      (dv),
    .i_RX_Byte    (rx_byte),
    .o_Data       (data),
    .o_Data_Valid (valid),
    .o_Data_Last  (last),
    .i_Data_Ready (ready),
    .o_Frame_Err  (ferr),
    .o_Err_Code   (code),
    .o_Overrun    (ovr),
    .o_Busy       (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] cap_d [$];
  logic       cap_l [$];
  int         cap_t [$];
  int         err_cnt = 0;
  logic [1:0] err_code_seen = 2'b00;
  int         ovr_cnt = 0;
  int         code_glitch = 0;
  logic       valid_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && ready) begin
      cap_d.push_back(data);
      cap_l.push_back(last);
      cap_t.push_back(cyc);
    end
    if (valid) valid_seen = 1'b1;
    if (ferr) begin
      err_cnt++;
      err_code_seen = code;
    end
    if (!ferr && code != 2'b00) code_glitch++;
    if (ovr) ovr_cnt++;
  end

  task automatic clear_mon();
    cap_d.delete();
    cap_l.delete();
    cap_t.delete();
    err_cnt = 0;
    err_code_seen = 2'b00;
    ovr_cnt = 0;
    valid_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    dv = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv = 1'b0;
    rx_byte = 8'h00;
  endtask

  // Vector table: stimulus and expected stream are slices of flat arrays.
  typedef struct packed {
    int         s_off;
    int         s_n;
    int         e_off;
    int         e_n;
    int         exp_err;
    logic [1:0] exp_code;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  logic [7:0] stim [32] = '{
    8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97,             // 0: good
    8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98,             // 1: bad checksum
    8'hA5, 8'h00,                                         // 2: LEN 0
    8'hA5, 8'h11,                                         // 3: LEN 17
    8'hA5, 8'h01, 8'h5A, 8'hA5,                           // 4: 1 byte, CHK==SYNC
    8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hB4, // 5: junk, SYNC in payload
    8'hA5, 8'h01, 8'h00, 8'hFF                            // 6: zero payload byte
  };
  logic [7:0] exp_o [7] = '{8'h11, 8'h22, 8'h33, 8'h5A, 8'hA5, 8'hA5, 8'h00};

  function automatic vec_t mkv(input int so, input int sn, input int eo, input int en,
                               input int er, input logic [1:0] c);
    vec_t v;
    v.s_off = so; v.s_n = sn; v.e_off = eo; v.e_n = en; v.exp_err = er; v.exp_code = c;
    return v;
  endfunction

  task automatic run_vec(input int vi);
    vec_t v;
    v = vecs[vi];
    clear_mon();
    ready = 1'b1;
    for (int i = 0; i < v.s_n; i++) send_byte(stim[v.s_off + i]);
    repeat (20) @(negedge clk);
    chk($sformatf("v%0d_nout", vi), cap_d.size(), v.e_n);
    for (int j = 0; j < v.e_n && j < cap_d.size(); j++) begin
      chk($sformatf("v%0d_data%0d", vi, j), cap_d[j], exp_o[v.e_off + j]);
      chk($sformatf("v%0d_last%0d", vi, j), cap_l[j], (j == v.e_n - 1));
      chk($sformatf("v%0d_b2b%0d", vi, j), cap_t[j] - cap_t[0], j);
    end
    chk($sformatf("v%0d_errcnt", vi), err_cnt, v.exp_err);
    if (v.exp_err != 0) chk($sformatf("v%0d_code", vi), err_code_seen, v.exp_code);
    if (v.e_n == 0) chk($sformatf("v%0d_novalid", vi), valid_seen, 1'b0);
    chk($sformatf("v%0d_busy_idle", vi), busy, 1'b0);
  endtask

  initial begin
    int early;
    int unstable;
    logic [7:0] held;
    logic [7:0] pay [16];
    logic [7:0] sum;

    vecs[0] = mkv(0, 6, 0, 3, 0, 2'b00);
    vecs[1] = mkv(6, 6, 0, 0, 1, 2'b10);
    vecs[2] = mkv(12, 2, 0, 0, 1, 2'b01);
    vecs[3] = mkv(14, 2, 0, 0, 1, 2'b01);
    vecs[4] = mkv(16, 4, 3, 1, 0, 2'b00);
    vecs[5] = mkv(20, 8, 4, 2, 0, 2'b00);
    vecs[6] = mkv(28, 4, 6, 1, 0, 2'b00);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_last", last, 1'b0);
    chk("rst_err", ferr, 1'b0);
    chk("rst_code", code, 2'b00);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int vi = 0; vi < NV; vi++) run_vec(vi);

    // Backpressure with an overrun byte during the stall
    clear_mon();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(stim[i]);
    @(negedge clk);
    chk("bp_latency_valid", valid, 1'b1);
    chk("bp_first_data", data, 8'h11);
    chk("bp_first_last", last, 1'b0);
    send_byte(8'hEE);
    unstable = 0;
    held = data;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!valid || data !== held || last !== 1'b0) unstable++;
    end
    chk("bp_stable", unstable, 0);
    chk("bp_overrun_once", ovr_cnt, 1);
    @(posedge clk);
    #1 ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_nout", cap_d.size(), 3);
    for (int j = 0; j < 3 && j < cap_d.size(); j++) begin
      chk($sformatf("bp_data%0d", j), cap_d[j], exp_o[j]);
      chk($sformatf("bp_last%0d", j), cap_l[j], (j == 2));
    end
    chk("bp_errcnt", err_cnt, 0);

    // Inter-byte timeout
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    early = 0;
    for (int k = 0; k <= TMO; k++) begin
      @(negedge clk);
      if (k < TMO) begin
        if (ferr) early++;
      end else begin
        chk("tmo_err_at_T", ferr, 1'b1);
        chk("tmo_code", code, 2'b11);
      end
    end
    chk("tmo_early", early, 0);
    @(negedge clk);
    chk("tmo_pulse_1cyc", ferr, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    run_vec(0);

    // Reset in the middle of a payload
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_data", data, 8'h00);
    repeat (5) @(negedge clk);
    chk("mid_rst_noerr", err_cnt, 0);
    run_vec(5);

    // Maximum-length frame
    clear_mon();
    sum = 8'h10;
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'(i * 7 + 3);
      sum = sum + pay[i];
    end
    send_byte(8'hA5);
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(pay[i]);
    send_byte(8'h00 - sum);
    repeat (25) @(negedge clk);
    chk("max_nout", cap_d.size(), 16);
    for (int j = 0; j < 16 && j < cap_d.size(); j++) begin
      chk($sformatf("max_data%0d", j), cap_d[j], pay[j]);
      chk($sformatf("max_last%0d", j), cap_l[j], (j == 15));
    end
    chk("max_errcnt", err_cnt, 0);

    chk("code_zero_between_pulses", code_glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
